// File: rtl/rename_multiway_pkg.sv
// Shared sizing, typedefs and lane request struct for the multi-way rename stage.
package rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int RW        = 2;
    localparam int WB_PORTS  = 2;
    localparam int CW        = 2;

    localparam int ARCH_REGS_W = $clog2(ARCH_REGS);
    localparam int PREG_W      = $clog2(PHYS_REGS);
    localparam int PTR_W       = PREG_W + 1;

    typedef logic [ARCH_REGS_W-1:0] areg_t;
    typedef logic [PREG_W-1:0]      preg_t;
    typedef logic [PTR_W-1:0]       fl_ptr_t;

    typedef struct packed {
        areg_t rs1;
        areg_t rs2;
        areg_t rd;
    } ren_lane_t;
endpackage

// File: rtl/rename_multiway_if.sv
// Decode/CDB/commit-facing bundle of the rename stage; master drives, slave renames.
interface rename_multiway_if;
    import rename_pkg::*;

    logic [RW-1:0]             ren_valid;
    logic                      ren_ready;
    ren_lane_t [RW-1:0]        ren_lane;
    preg_t [RW-1:0]            prs1, prs2, prd, stale_prd;
    logic [RW-1:0]             prs1_rdy, prs2_rdy, out_valid;
    logic [WB_PORTS-1:0]       wb_valid;
    preg_t [WB_PORTS-1:0]      wb_prd;
    logic [CW-1:0]             commit_valid;
    areg_t [CW-1:0]            commit_ard;
    preg_t [CW-1:0]            commit_prd, commit_stale;
    logic                      flush;
    fl_ptr_t                   free_count;

    modport master (
        output ren_valid, ren_lane, wb_valid, wb_prd, flush,
               commit_valid, commit_ard, commit_prd, commit_stale,
        input  ren_ready, prs1, prs2, prd, stale_prd, prs1_rdy, prs2_rdy,
               out_valid, free_count
    );
    modport slave (
        input  ren_valid, ren_lane, wb_valid, wb_prd, flush,
               commit_valid, commit_ard, commit_prd, commit_stale,
        output ren_ready, prs1, prs2, prd, stale_prd, prs1_rdy, prs2_rdy,
               out_valid, free_count
    );
endinterface

// File: rtl/rename_freelist_mw.sv
// Circular physical-register free list: multi-pop at head, multi-push at tail,
// and a commit_head that head rewinds to on flush.
module rename_freelist_mw import rename_pkg::*; (
    input  logic              clk_i,
    input  logic              reset_i,
    input  fl_ptr_t           pop_cnt,
    input  logic [CW-1:0]     push_valid,
    input  preg_t [CW-1:0]    push_preg,
    input  logic [CW-1:0]     commit_adv,
    input  logic              flush,
    output preg_t [RW-1:0]    head_preg,
    output fl_ptr_t           free_count
);
    preg_t   mem [PHYS_REGS];
    fl_ptr_t head_q, cmt_head_q, tail_q, cmt_head_d;
    fl_ptr_t push_off [CW];
    fl_ptr_t push_n, adv_n;

    // Pushes pack densely in lane order; skipped lanes take no slot.
    always_comb begin
        push_n = '0;
        adv_n  = '0;
        for (int c = 0; c < CW; c++) begin
            push_off[c] = push_n;
            if (push_valid[c]) push_n = push_n + fl_ptr_t'(1);
            if (commit_adv[c]) adv_n = adv_n + fl_ptr_t'(1);
        end
        cmt_head_d = cmt_head_q + adv_n;
    end

    always_comb begin
        for (int i = 0; i < RW; i++)
            head_preg[i] = mem[preg_t'(head_q + fl_ptr_t'(i))];
    end

    assign free_count = tail_q - head_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= '0;
            cmt_head_q <= '0;
            tail_q     <= fl_ptr_t'(PHYS_REGS - ARCH_REGS);
            for (int i = 0; i < PHYS_REGS; i++)
                mem[i] <= (i < PHYS_REGS - ARCH_REGS) ? preg_t'(ARCH_REGS + i) : '0;
        end else begin
            for (int c = 0; c < CW; c++)
                if (push_valid[c]) mem[preg_t'(tail_q + push_off[c])] <= push_preg[c];
            tail_q     <= tail_q + push_n;
            cmt_head_q <= cmt_head_d;
            head_q     <= flush ? cmt_head_d : head_q + pop_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (int'(free_count) + int'(push_n) - int'(pop_cnt) <= PHYS_REGS)
                else $error("rename_freelist_mw: push to a full free list");
    end
endmodule

// File: rtl/rename_multiway.sv
// RW-wide register rename: speculative + committed RAT, busy table, free list.
// Define RENAME_WB_BYPASS_EN to let same-cycle CDB writebacks mark sources ready.
module rename_multiway import rename_pkg::*; (
    input  logic              clk_i,
    input  logic              reset_i,
    rename_multiway_if.slave  bus
);
    localparam int LANE_W = (RW > 1) ? $clog2(RW) : 1;
    typedef logic [LANE_W:0] slot_t;

    preg_t [ARCH_REGS-1:0] spec_rat, cmt_rat, cmt_rat_d;
    logic  [PHYS_REGS-1:0] busy_q, busy_d;
    ren_lane_t [RW-1:0]    lane;
    preg_t [RW-1:0]        fl_head, new_prd, src1, src2, stale;
    logic  [RW-1:0]        alloc, rdy1, rdy2;
    logic  [CW-1:0]        push_valid, commit_adv;
    slot_t                 slot;
    fl_ptr_t               free_count, pop_cnt;
    logic                  ready, accept;

    logic  [RW-1:0]        out_valid_q, rdy1_q, rdy2_q;
    preg_t [RW-1:0]        prs1_q, prs2_q, prd_q, stale_q;

    assign lane   = bus.ren_lane;
    assign ready  = (free_count >= fl_ptr_t'(RW)) && !bus.flush;
    assign accept = (|bus.ren_valid) && ready;

`ifdef RENAME_WB_BYPASS_EN
    function automatic logic wb_hit(input preg_t p, input logic [WB_PORTS-1:0] v,
                                    input preg_t [WB_PORTS-1:0] r);
        wb_hit = 1'b0;
        for (int w = 0; w < WB_PORTS; w++)
            if (v[w] && (r[w] == p)) wb_hit = 1'b1;
    endfunction
`endif

    // Later lanes see earlier lanes' fresh mappings; a forwarded source is never ready.
    always_comb begin
        slot = '0;
        for (int k = 0; k < RW; k++) begin
            alloc[k]   = bus.ren_valid[k] && (lane[k].rd != '0);
            new_prd[k] = alloc[k] ? fl_head[slot[LANE_W-1:0]] : '0;
            if (alloc[k]) slot = slot + slot_t'(1);
            src1[k]  = spec_rat[lane[k].rs1];
            src2[k]  = spec_rat[lane[k].rs2];
            stale[k] = (lane[k].rd != '0) ? spec_rat[lane[k].rd] : '0;
            rdy1[k]  = !busy_q[src1[k]];
            rdy2[k]  = !busy_q[src2[k]];
`ifdef RENAME_WB_BYPASS_EN
            rdy1[k]  = rdy1[k] || wb_hit(src1[k], bus.wb_valid, bus.wb_prd);
            rdy2[k]  = rdy2[k] || wb_hit(src2[k], bus.wb_valid, bus.wb_prd);
`endif
            for (int j = 0; j < k; j++) begin
                if (alloc[j] && (lane[j].rd == lane[k].rs1)) begin
                    src1[k] = new_prd[j];
                    rdy1[k] = 1'b0;
                end
                if (alloc[j] && (lane[j].rd == lane[k].rs2)) begin
                    src2[k] = new_prd[j];
                    rdy2[k] = 1'b0;
                end
                if (alloc[j] && (lane[j].rd == lane[k].rd)) stale[k] = new_prd[j];
            end
        end
        pop_cnt = accept ? fl_ptr_t'(slot) : '0;
    end

    // Committed RAT including this cycle's retirements; flush copies from here.
    always_comb begin
        cmt_rat_d = cmt_rat;
        for (int c = 0; c < CW; c++) begin
            commit_adv[c] = bus.commit_valid[c] && (bus.commit_ard[c] != '0);
            push_valid[c] = bus.commit_valid[c] && (bus.commit_stale[c] != '0);
            if (commit_adv[c]) cmt_rat_d[bus.commit_ard[c]] = bus.commit_prd[c];
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < WB_PORTS; w++)
            if (bus.wb_valid[w]) busy_d[bus.wb_prd[w]] = 1'b0;
        if (accept)
            for (int k = 0; k < RW; k++)
                if (alloc[k]) busy_d[new_prd[k]] = 1'b1;
        busy_d[0] = 1'b0;
        if (bus.flush) busy_d = '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_rat[i] <= preg_t'(i);
                cmt_rat[i]  <= preg_t'(i);
            end
            busy_q <= '0;
        end else begin
            cmt_rat <= cmt_rat_d;
            busy_q  <= busy_d;
            if (bus.flush)
                spec_rat <= cmt_rat_d;
            else if (accept)
                for (int k = 0; k < RW; k++)
                    if (alloc[k]) spec_rat[lane[k].rd] <= new_prd[k];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_q <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            prs1_q      <= '0;
            prs2_q      <= '0;
            prd_q       <= '0;
            stale_q     <= '0;
        end else begin
            out_valid_q <= accept ? bus.ren_valid : '0;
            if (accept) begin
                rdy1_q  <= rdy1;
                rdy2_q  <= rdy2;
                prs1_q  <= src1;
                prs2_q  <= src2;
                prd_q   <= new_prd;
                stale_q <= stale;
            end
        end
    end

    rename_freelist_mw u_freelist (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .pop_cnt    (pop_cnt),
        .push_valid (push_valid),
        .push_preg  (bus.commit_stale),
        .commit_adv (commit_adv),
        .flush      (bus.flush),
        .head_preg  (fl_head),
        .free_count (free_count)
    );

    assign bus.ren_ready  = ready;
    assign bus.free_count = free_count;
    assign bus.out_valid  = out_valid_q;
    assign bus.prs1       = prs1_q;
    assign bus.prs2       = prs2_q;
    assign bus.prd        = prd_q;
    assign bus.stale_prd  = stale_q;
    assign bus.prs1_rdy   = rdy1_q;
    assign bus.prs2_rdy   = rdy2_q;
endmodule

// File: tb/tb_rename_multiway.sv
// Directed bench for rename_multiway: allocation, forwarding, busy/wakeup,
// commit/flush recovery, free-list drain and wrap, asynchronous reset.
module tb_rename_multiway;
    import rename_pkg::*;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    rename_multiway_if bus();
    rename_multiway dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

    always #5 clk_i = ~clk_i;

`ifdef RENAME_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lane(input string tag, input bit k, input int p1, input int r1,
                            input int p2, input int r2, input int pd, input int st);
        chk({tag, ".prs1"},  32'(bus.prs1[k]),      p1);
        chk({tag, ".rdy1"},  32'(bus.prs1_rdy[k]),  r1);
        chk({tag, ".prs2"},  32'(bus.prs2[k]),      p2);
        chk({tag, ".rdy2"},  32'(bus.prs2_rdy[k]),  r2);
        chk({tag, ".prd"},   32'(bus.prd[k]),       pd);
        chk({tag, ".stale"}, 32'(bus.stale_prd[k]), st);
    endtask

    task automatic clr();
        bus.ren_valid    = '0;
        bus.ren_lane     = '0;
        bus.wb_valid     = '0;
        bus.wb_prd       = '0;
        bus.commit_valid = '0;
        bus.commit_ard   = '0;
        bus.commit_prd   = '0;
        bus.commit_stale = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic set_lane(input bit k, input int rs1, input int rs2, input int rd);
        bus.ren_valid[k]    = 1'b1;
        bus.ren_lane[k].rs1 = areg_t'(rs1);
        bus.ren_lane[k].rs2 = areg_t'(rs2);
        bus.ren_lane[k].rd  = areg_t'(rd);
    endtask

    task automatic set_commit(input bit c, input int ard, input int prd, input int stale);
        bus.commit_valid[c] = 1'b1;
        bus.commit_ard[c]   = areg_t'(ard);
        bus.commit_prd[c]   = preg_t'(prd);
        bus.commit_stale[c] = preg_t'(stale);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_a, exp_b, va, vb;
        clr();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.count", 32'(bus.free_count), 32);
        chk("rst.ready", 32'(bus.ren_ready), 1);
        chk("rst.oval",  32'(bus.out_valid), 0);
        chk("rst.prd0",  32'(bus.prd[0]), 0);
        reset_i = 1'b0;

        // two-lane group with intra-group RAW on x5
        clr(); set_lane(0, 1, 2, 5); set_lane(1, 5, 0, 6); step();
        chk("g1.oval", 32'(bus.out_valid), 3);
        chk_lane("g1.l0", 0, 1, 1, 2, 1, 32, 5);
        chk_lane("g1.l1", 1, 32, 0, 0, 1, 33, 6);
        chk("g1.count", 32'(bus.free_count), 30);

        clr(); set_lane(0, 5, 6, 0); step();
        chk("busy.oval", 32'(bus.out_valid), 1);
        chk_lane("busy.l0", 0, 32, 0, 33, 0, 0, 0);

        // writeback of p32 in the same cycle as the read
        clr(); set_lane(0, 5, 6, 0); bus.wb_valid[0] = 1'b1; bus.wb_prd[0] = 6'd32; step();
        chk_lane("wbsame.l0", 0, 32, BYP, 33, 0, 0, 0);

        // wakeup visible; p34 allocated and written back together -> stays busy
        clr(); set_lane(0, 5, 6, 0); set_lane(1, 6, 5, 7);
        bus.wb_valid[1] = 1'b1; bus.wb_prd[1] = 6'd34; step();
        chk_lane("wake.l0", 0, 32, 1, 33, 0, 0, 0);
        chk_lane("wake.l1", 1, 33, 0, 32, 1, 34, 7);
        chk("wake.count", 32'(bus.free_count), 29);

        // rd=0 on both lanes; set-wins on p34
        clr(); set_lane(0, 7, 0, 0); set_lane(1, 0, 0, 0); step();
        chk("rd0.oval", 32'(bus.out_valid), 3);
        chk_lane("rd0.l0", 0, 34, 0, 0, 1, 0, 0);
        chk_lane("rd0.l1", 1, 0, 1, 0, 1, 0, 0);
        chk("rd0.count", 32'(bus.free_count), 29);

        // both lanes write x8: stale and source of lane1 forward from lane0
        clr(); set_lane(0, 0, 0, 8); set_lane(1, 8, 7, 8); step();
        chk_lane("waw.l0", 0, 0, 1, 0, 1, 35, 8);
        chk_lane("waw.l1", 1, 35, 0, 34, 0, 36, 35);
        chk("waw.count", 32'(bus.free_count), 27);

        clr(); step();
        chk("idle.oval", 32'(bus.out_valid), 0);

        // flush with same-cycle commit of the first group and a blocked rename
        clr(); bus.flush = 1'b1; set_commit(0, 5, 32, 5); set_commit(1, 6, 33, 6);
        set_lane(0, 0, 0, 9);
        #1;
        chk("flush.ready", 32'(bus.ren_ready), 0);
        step();
        chk("flush.oval",  32'(bus.out_valid), 0);
        chk("flush.count", 32'(bus.free_count), 32);

        clr(); set_lane(0, 5, 6, 0); set_lane(1, 7, 8, 0); step();
        chk_lane("rec.l0", 0, 32, 1, 33, 1, 0, 0);
        chk_lane("rec.l1", 1, 7, 1, 8, 1, 0, 0);
        chk("rec.count", 32'(bus.free_count), 32);

        // commit with ard=0 must leave RAT and commit_head alone
        clr(); set_commit(0, 0, 40, 0); step();
        chk("ard0.count", 32'(bus.free_count), 32);
        clr(); bus.flush = 1'b1; step();
        chk("ard0.fcount", 32'(bus.free_count), 32);
        clr(); set_lane(0, 0, 0, 0); set_lane(1, 9, 5, 0); step();
        chk_lane("ard0.l0", 0, 0, 1, 0, 1, 0, 0);
        chk_lane("ard0.l1", 1, 9, 1, 32, 1, 0, 0);

        // drain to a single free entry
        for (int g = 0; g < 15; g++) begin
            clr(); set_lane(0, 0, 0, 10); set_lane(1, 0, 0, 11); step();
        end
        chk("drain.count2", 32'(bus.free_count), 2);
        clr(); set_lane(0, 0, 0, 12); step();
        chk("drain.prd", 32'(bus.prd[0]), 5);
        chk("drain.stale", 32'(bus.stale_prd[0]), 12);
        chk("drain.count1", 32'(bus.free_count), 1);
        chk("drain.ready", 32'(bus.ren_ready), 0);
        clr(); set_lane(0, 0, 0, 13); set_lane(1, 0, 0, 14); step();
        chk("drain.blocked", 32'(bus.out_valid), 0);
        chk("drain.held", 32'(bus.free_count), 1);
        clr(); set_commit(0, 12, 5, 9); step();
        chk("drain.refill", 32'(bus.free_count), 2);
        chk("drain.ready2", 32'(bus.ren_ready), 1);

        // steady pop-2/push-2 until both pointers wrap past 2*PHYS_REGS
        exp_a = 6;
        exp_b = 9;
        for (int i = 0; i < 60; i++) begin
            va = 10 + (2 * i) % 50;
            vb = va + 1;
            clr(); set_lane(0, 0, 0, 10); set_lane(1, 0, 0, 11);
            set_commit(0, 10, 1, va); set_commit(1, 11, 1, vb);
            step();
            chk("wrap.prd0", 32'(bus.prd[0]), exp_a);
            chk("wrap.prd1", 32'(bus.prd[1]), exp_b);
            chk("wrap.count", 32'(bus.free_count), 2);
            exp_a = va;
            exp_b = vb;
        end

        // asynchronous reset in the middle of a group
        clr(); set_lane(0, 1, 1, 3); set_lane(1, 2, 2, 4);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst.oval",  32'(bus.out_valid), 0);
        chk("arst.prd0",  32'(bus.prd[0]), 0);
        chk("arst.count", 32'(bus.free_count), 32);
        chk("arst.ready", 32'(bus.ren_ready), 1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        clr(); set_lane(0, 5, 0, 0); set_lane(1, 10, 12, 0); step();
        chk_lane("arst.l0", 0, 5, 1, 0, 1, 0, 0);
        chk_lane("arst.l1", 1, 10, 1, 12, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
